mem_responder: RTL and testbench

- Memory-side responder for the multicycle core's data/instruction memory port.
- Accepts one read or write request at a time from the core's initiator side (driven by the control FSM's MEM_RD/MEM_WR phases).
- Services each request after a configurable wait-state count, using an internal byte-writable word array.
- Returns a one-cycle response pulse with read data or an error flag; sits between the core datapath and on-chip RAM.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_word_array.sv | 30 +++
 rtl/mem_responder.sv | 130 +++++++++++++
 tb/tb_mem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  // Value driven on resp_err for a rejected (misaligned / out-of-range) request.
  localparam logic ERR_RESP = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_word_array.sv
// Synchronous byte-writable word array; the read port returns the pre-write word.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      if (we) begin
        for (int unsigned i = 0; i < STRB_W; i++) begin
          if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, LATENCY wait states, one-cycle response pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              busy,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              hold_write_q;
  logic [31:0]       hold_addr_q;
  logic [WORD_W-1:0] hold_wdata_q;
  logic [STRB_W-1:0] hold_wstrb_q;
  logic              err_q;
  logic              rdata_zero_q;

  logic              sel_write;
  logic [31:0]       sel_addr;
  logic [WORD_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              sel_err;
  logic              access;
  logic [WORD_W-1:0] arr_rdata;

  // With LATENCY=0 the access edge is the accept edge, so the live request
  // feeds the array in IDLE; afterwards the held copy does.
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_write = req_write;
      sel_addr  = req_addr;
      sel_wdata = req_wdata;
      sel_wstrb = req_wstrb;
    end else begin
      sel_write = hold_write_q;
      sel_addr  = hold_addr_q;
      sel_wdata = hold_wdata_q;
      sel_wstrb = hold_wstrb_q;
    end
    sel_err = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= 30'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_d = S_RESP;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (access) begin
        err_q        <= sel_err;
        rdata_zero_q <= sel_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      hold_write_q <= req_write;
      hold_addr_q  <= req_addr;
      hold_wdata_q <= req_wdata;
      hold_wstrb_q <= req_wstrb;
    end
  end

  mem_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (access && !sel_err && resetn),
    .we    (sel_write),
    .wstrb (sel_wstrb),
    .idx   (sel_addr[AW+1:2]),
    .wdata (sel_wdata),
    .rdata (arr_rdata)
  );

  // Array read register is not reset; masking gives zero after reset and on errors.
  assign resp_rdata = rdata_zero_q ? '0 : arr_rdata;
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = (state_q == S_RESP) && (err_q == ERR_RESP);

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder (DEPTH=1024, LATENCY=2).
module tb_mem_responder;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
      end
    end
  end

  // One full transaction; checks busy during wait, latency, and single-cycle pulse.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] exp_rdata, input logic exp_err);
    int unsigned n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    sb.push_back(e);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_wait", 32'(busy), 32'd1);
    end while (!resp_valid && n < 20);
    chk("resp_latency", n, LATENCY + 1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pulse_width", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned first_cyc;
    int unsigned pulses;
    exp_t e;

    resetn    = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_no_resp", 32'(resp_valid), 32'd0);
    end

    // Known contents for later "unchanged" checks (array is not reset).
    do_req(1'b1, 32'h0,  32'hA5A5_0F0F, 4'hF, 32'hx, 1'b0);
    do_req(1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'hx, 1'b0);
    sb.delete();

    // Write then read back.
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'hx, 1'b0);
    sb.delete();
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte strobes: returns pre-write word, merges lanes 0 and 2.
    do_req(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

    // Zero strobe: normal response, no change.
    do_req(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'hDE22_BE44, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 32'hDE22_BE44, 1'b0);

    // Errors: misaligned read, out-of-range write, then word 0 unchanged.
    do_req(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
    chk("rdata_hold_after_err", resp_rdata, 32'h0);
    chk("err_clears_idle", 32'(resp_err), 32'd0);
    do_req(1'b1, DEPTH * 4, 32'h5555_5555, 4'hF, 32'h0, 1'b1);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 32'hA5A5_0F0F, 1'b0);
    do_req(1'b0, (DEPTH - 1) * 4, 32'h0, 4'h0, 32'hx, 1'b0);
    sb.delete();

    // Back-to-back: req_valid held, second request swapped in on the first response.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    e.rdata = 32'hDE22_BE44; e.err = 1'b0;
    sb.push_back(e);
    cyc = 0;
    pulses = 0;
    first_cyc = 0;
    while (pulses < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        pulses++;
        if (pulses == 1) begin
          first_cyc = cyc;
          req_addr  = 32'h0;
          e.rdata = 32'hA5A5_0F0F; e.err = 1'b0;
          sb.push_back(e);
        end else begin
          chk("b2b_spacing", cyc - first_cyc, LATENCY + 2);
        end
      end
    end
    chk("b2b_pulses", pulses, 32'd2);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Mid-operation reset: write aborted, no response, old contents kept.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFE_F00D;
    req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    resetn    = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
